fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-bit-opcode, 32-bit pipeline; sits directly upstream of decode.
- Owns the program counter and issues single-outstanding requests to instruction memory.
- Buffers returned instructions in an IF/ID output register plus a 1-entry skid buffer.
- Presents inst_o/pc_o to decode; honours decode stalls and branch redirects (Branch/BrPC from decode).

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_skid_buf.sv | 78 +++++++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 32-bit pipeline front end.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_KILL = 2'd2
  } fetch_state_t;

  // One fetched instruction tagged with its byte address.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// IF/ID output register plus a one-entry skid buffer with load/drain/flush.
module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         stall_i,
  input  logic         load_i,
  input  fetch_entry_t load_data_i,
  output logic         out_valid_o,
  output fetch_entry_t out_data_o,
  output logic         skid_valid_next_c
);

  logic         out_valid_q, out_valid_d;
  fetch_entry_t out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  fetch_entry_t skid_data_q, skid_data_d;

  // Next occupancy: flush wins, then drain/consume, then a plain load.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_valid_q && !stall_i) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = load_i;
        if (load_i) begin
          skid_data_d = load_data_i;
        end
      end else if (load_i) begin
        out_data_d = load_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (load_i) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = load_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = load_data_i;
      end
    end
    // Invalid slot presents a bubble; the pc of the last load is kept.
    if (!out_valid_d) begin
      out_data_d.inst = NOP_INST;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '{inst: NOP_INST, pc: '0};
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid_o       = out_valid_q;
  assign out_data_o        = out_data_q;
  assign skid_valid_next_c = skid_valid_d;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requests, redirect handling.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall_i,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            rsp_c;
  logic            issue_c;
  logic            skid_valid_next_c;
  logic            out_valid;
  fetch_entry_t    out_data;
  fetch_entry_t    rsp_data;

  // Only a response to a live request is loaded; kill-state and idle returns are dropped.
  assign rsp_c    = (state_q == WAIT) && imem_rvalid && !br_taken;
  assign rsp_data = '{inst: imem_rdata, pc: req_pc_q};

  // A new request needs the port free, no redirect, and room in the buffers after this edge.
  assign issue_c = !br_taken && !skid_valid_next_c &&
                   ((state_q == IDLE) || ((state_q == WAIT) && imem_rvalid));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue_c) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = issue_c ? WAIT : IDLE;
        end else if (br_taken) begin
          state_d = WAIT_KILL;
        end
      end
      WAIT_KILL: begin
        if (imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // PC update and request tagging; redirect overrides any issue.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (br_taken) begin
      fetch_pc_d = br_pc;
    end else if (issue_c) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
      req_pc_d   = fetch_pc_q;
    end
  end

  // PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  // Request strobe is held low for the whole reset window.
  assign imem_req  = issue_c && rst_n;
  assign imem_addr = fetch_pc_q;

  fetch_skid_buf #(
    .NOP_INST (NOP_INST)
  ) u_skid (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush_i           (br_taken),
    .stall_i           (stall_i),
    .load_i            (rsp_c),
    .load_data_i       (rsp_data),
    .out_valid_o       (out_valid),
    .out_data_o        (out_data),
    .skid_valid_next_c (skid_valid_next_c)
  );

  assign valid_o = out_valid;
  assign inst_o  = out_data.inst;
  assign pc_o    = out_data.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle tables plus random traffic against a stream model.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        valid_o;

  int n_cmp;
  int n_bad;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall_i     (stall_i),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .inst_o      (inst_o),
    .pc_o        (pc_o),
    .valid_o     (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] brpc;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic vec_t mk(input logic st, input logic br, input logic [31:0] bpc,
                              input logic rv, input logic [31:0] rd,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.stall = st; v.br = br; v.brpc = bpc; v.rv = rv; v.rdata = rd;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive a cycle, check mid-cycle, advance to next posedge+1.
  task automatic apply_vec(input string tag, input vec_t v);
    stall_i     = v.stall;
    br_taken    = v.br;
    br_pc       = v.brpc;
    imem_rvalid = v.rv;
    imem_rdata  = v.rdata;
    #3;
    chk1({tag, "_req"}, imem_req, v.e_req);
    if (v.e_req) chk32({tag, "_addr"}, imem_addr, v.e_addr);
    chk1({tag, "_valid"}, valid_o, v.e_valid);
    if (v.e_valid) chk32({tag, "_pc"}, pc_o, v.e_pc);
    chk32({tag, "_inst"}, inst_o, v.e_valid ? mem_word(v.e_pc) : NOP_INST_DEF);
    @(posedge clk);
    #1;
  endtask

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      apply_vec($sformatf("%s%0d", tag, i), tbl[i]);
    end
    tbl.delete();
  endtask

  // Asserts reset, checks outputs immediately, releases at posedge+1.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    stall_i = 1'b0; br_taken = 1'b0; br_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0;
    #1;
    chk1({tag, "_rst_valid"}, valid_o, 1'b0);
    chk32({tag, "_rst_inst"}, inst_o, NOP_INST_DEF);
    chk32({tag, "_rst_pc"}, pc_o, 32'h0);
    chk1({tag, "_rst_req"}, imem_req, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_req, exp_acc, m_addr, bpc;
  logic        m_pend, rv_now, st, br;
  int          m_cnt, n_acc;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    stall_i = 1'b0; br_taken = 1'b0; br_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk);
    #1;
    do_reset("a");

    // Streaming, stall with skid fill, redirect during outstanding request, redirect with rvalid+stall.
    //           st br brpc        rv rdata                 req addr         v  pc
    tbl.push_back(mk(0, 0, 0,          0, 0,                  1, 32'h0,       0, 0));
    tbl.push_back(mk(0, 0, 0,          1, mem_word(32'h0),    1, 32'h4,       0, 0));
    tbl.push_back(mk(0, 0, 0,          1, mem_word(32'h4),    1, 32'h8,       1, 32'h0));
    tbl.push_back(mk(1, 0, 0,          1, mem_word(32'h8),    0, 0,           1, 32'h4));
    tbl.push_back(mk(1, 0, 0,          0, 0,                  0, 0,           1, 32'h4));
    tbl.push_back(mk(1, 0, 0,          0, 0,                  0, 0,           1, 32'h4));
    tbl.push_back(mk(0, 0, 0,          0, 0,                  1, 32'hC,       1, 32'h4));
    tbl.push_back(mk(0, 0, 0,          1, mem_word(32'hC),    1, 32'h10,      1, 32'h8));
    tbl.push_back(mk(0, 1, 32'h100,    0, 0,                  0, 0,           1, 32'hC));
    tbl.push_back(mk(0, 0, 0,          0, 0,                  0, 0,           0, 0));
    tbl.push_back(mk(0, 0, 0,          1, mem_word(32'h10),   0, 0,           0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,                  1, 32'h100,     0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0,                  0, 0,           0, 0));
    tbl.push_back(mk(0, 0, 0,          1, mem_word(32'h100),  1, 32'h104,     0, 0));
    tbl.push_back(mk(1, 1, 32'h200,    1, mem_word(32'h104),  0, 0,           1, 32'h100));
    tbl.push_back(mk(0, 0, 0,          0, 0,                  1, 32'h200,     0, 0));
    tbl.push_back(mk(0, 0, 0,          1, mem_word(32'h200),  1, 32'h204,     0, 0));
    tbl.push_back(mk(0, 0, 0,          1, mem_word(32'h204),  1, 32'h208,     1, 32'h200));
    tbl.push_back(mk(0, 0, 0,          0, 0,                  0, 0,           1, 32'h204));
    run_tbl("a");

    // PC wrap from the top of the address space.
    do_reset("w");
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0,                     0, 0,            0, 0));
    tbl.push_back(mk(0, 0, 0,             0, 0,                     1, 32'hFFFF_FFFC, 0, 0));
    tbl.push_back(mk(0, 0, 0,             1, mem_word(32'hFFFF_FFFC), 1, 32'h0,      0, 0));
    tbl.push_back(mk(0, 0, 0,             1, mem_word(32'h0),       1, 32'h4,        1, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 0, 0,             0, 0,                     0, 0,            1, 32'h0));
    run_tbl("w");

    // Fill the skid, reset mid-flight, then a stale rvalid right after release must be ignored.
    do_reset("s");
    tbl.push_back(mk(0, 0, 0, 0, 0,               1, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, mem_word(32'h0), 1, 32'h4, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, mem_word(32'h4), 0, 0,     1, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0,               0, 0,     1, 32'h0));
    run_tbl("s");
    do_reset("m");
    tbl.push_back(mk(0, 0, 0, 1, 32'hBAD0_BAD0,   1, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, mem_word(32'h0), 1, 32'h4, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,               0, 0,     1, 32'h0));
    run_tbl("m");

    // Random traffic: delivered stream must be the sequential program from the last redirect.
    do_reset("r");
    exp_req = RESET_PC_DEF; exp_acc = RESET_PC_DEF;
    m_pend = 1'b0; m_cnt = 0; m_addr = '0; n_acc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rv_now = m_pend && (m_cnt == 0);
      st  = ($urandom_range(99) < 30);
      br  = ($urandom_range(99) < 5);
      bpc = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      stall_i = st; br_taken = br; br_pc = bpc;
      imem_rvalid = rv_now;
      imem_rdata  = rv_now ? mem_word(m_addr) : $urandom;
      #3;
      if (!valid_o) chk32("rnd_bubble_inst", inst_o, NOP_INST_DEF);
      if (br) chk1("rnd_no_req_on_redirect", imem_req, 1'b0);
      if (m_pend && !rv_now) chk1("rnd_one_outstanding", imem_req, 1'b0);
      if (imem_req && !br) chk32("rnd_req_addr", imem_addr, exp_req);
      if (valid_o && !st && !br) begin
        chk32("rnd_acc_pc", pc_o, exp_acc);
        chk32("rnd_acc_inst", inst_o, mem_word(exp_acc));
        exp_acc = exp_acc + 32'd4;
        n_acc++;
      end
      if (imem_req) exp_req = exp_req + 32'd4;
      if (br) begin
        exp_req = bpc;
        exp_acc = bpc;
      end
      if (m_pend && !rv_now) m_cnt--;
      if (rv_now) m_pend = 1'b0;
      if (imem_req) begin
        m_pend = 1'b1;
        m_addr = imem_addr;
        m_cnt  = int'($urandom_range(2));
      end
      @(posedge clk);
      #1;
    end
    chk1("rnd_progress", n_acc >= 200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
